// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, round constants and the
// key-schedule FSM state encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } ks_state_e;

  // Round constant for round i (1..10); index 0 and 11..15 are never used.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/subword_rot.sv
// RotWord followed by SubWord on one 32-bit key word, four shared S-boxes.
module subword_rot (
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);

  logic [31:0] rot;

  // RotWord: cyclic left shift by one byte, [a0,a1,a2,a3] -> [a1,a2,a3,a0].
  assign rot = {w_i[23:0], w_i[31:24]};

  sbox u_sbox0 (.a_i(rot[31:24]), .s_o(w_o[31:24]));
  sbox u_sbox1 (.a_i(rot[23:16]), .s_o(w_o[23:16]));
  sbox u_sbox2 (.a_i(rot[15:8]),  .s_o(w_o[15:8]));
  sbox u_sbox3 (.a_i(rot[7:0]),   .s_o(w_o[7:0]));

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 round-key generator for decryption: runs the forward
// schedule up to round key 10, then walks back to round key 0 with the
// inverse recurrence, one key per handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. key_ready and rk_valid are decoded from the state register only,
// never from key_valid or rk_ready; while rk_valid is high and rk_ready is
// low, rk/rk_round/rk_last are held stable.
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy,
  output ks_state_e    dbg_state
);

  ks_state_e    state_q, state_d;
  logic [127:0] w_q, w_d;
  logic [3:0]   cnt_q, cnt_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p3;
  logic [31:0]  sub_in, sub_out, t;
  logic [3:0]   rcon_idx;
  logic [127:0] fwd_w, inv_w;

  assign w0 = w_q[127:96];
  assign w1 = w_q[95:64];
  assign w2 = w_q[63:32];
  assign w3 = w_q[31:0];

  // Previous round's w3, needed by the inverse step before SubWord.
  assign p3 = w3 ^ w2;

  // One SubWord serves both directions: forward uses w3, inverse uses p3.
  assign sub_in   = (state_q == EMIT) ? p3 : w3;
  // Forward produces round cnt+1; inverse undoes round cnt.
  assign rcon_idx = (state_q == FWD) ? (cnt_q + 4'd1) : cnt_q;

  subword_rot u_subword_rot (
    .w_i(sub_in),
    .w_o(sub_out)
  );

  assign t = sub_out ^ {rcon(rcon_idx), 24'h0};

  // Forward step: chained XOR n0..n3.
  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0    = w0 ^ t;
    n1    = w1 ^ n0;
    n2    = w2 ^ n1;
    n3    = w3 ^ n2;
    fwd_w = {n0, n1, n2, n3};
  end

  // Inverse step: recover the previous round key.
  assign inv_w = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};

  // Next-state, working-key and counter update.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          w_d     = key;
          cnt_d   = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        w_d   = fwd_w;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR - 1)) state_d = EMIT;
      end
      EMIT: begin
        if (rk_ready) begin
          if (cnt_q != 4'd0) begin
            w_d   = inv_w;
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working key and counter registers; reset aborts any schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from registered state only; rk fields read zero unless emitting.
  always_comb begin
    key_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rk_valid  = (state_q == EMIT);
    rk        = rk_valid ? w_q : '0;
    rk_round  = rk_valid ? cnt_q : 4'd0;
    rk_last   = rk_valid && (cnt_q == 4'd0);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 key schedules in reverse,
// stalls, ignored keys while busy, async reset mid-emit, back-to-back keys.
module tb_inv_key_schedule;
  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;
  ks_state_e    dbg_state;

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_round(rk_round), .rk_last(rk_last), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [127:0]        key;
    logic [10:0][127:0]  rks;   // rks[r] = round key r
    logic                stall;
    logic                poke;
  } vec_t;

  logic [10:0][127:0] ks_a, ks_c;
  vec_t vecs[4];

  // ---------------- driver tasks ----------------
  // All tasks begin and end one time unit after a rising edge.
  task automatic start_key(input logic [127:0] k);
    key       = k;
    key_valid = 1'b1;
    check("key_ready_idle", 128'(key_ready), 128'(1));
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("busy_after_accept", 128'(busy), 128'(1));
  endtask

  task automatic run_key(input logic [127:0] k, input logic [10:0][127:0] rks,
                         input bit stall, input bit poke,
                         input logic [127:0] poke_key, input bit keep_valid);
    int   cyc;
    int   hs;
    int   guard;
    int   round;
    logic rr;
    start_key(k);
    cyc = 0;
    while (rk_valid !== 1'b1 && cyc < 40) begin
      if (poke) begin
        key_valid = 1'b1;
        key       = poke_key;
        check("key_ready_fwd", 128'(key_ready), 128'(0));
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("first_key_latency", 128'(cyc), 128'(10));
    for (int r = 10; r >= 0; r--) exp_q.push_back(rks[r]);
    hs    = 0;
    guard = 0;
    round = 10;
    while (exp_q.size() > 0 && guard < 200) begin
      rr       = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rr;
      if (poke) begin
        key_valid = 1'b1;
        key       = poke_key;
        check("key_ready_emit", 128'(key_ready), 128'(0));
      end
      check("rk_valid", 128'(rk_valid), 128'(1));
      check("rk", rk, exp_q[0]);
      check("rk_round", 128'(rk_round), 128'(round));
      check("rk_last", 128'(rk_last), 128'(round == 0));
      if (rr) begin
        void'(exp_q.pop_front());
        hs++;
        round--;
      end
      @(posedge clk); #1;
      guard++;
    end
    exp_q.delete();
    rk_ready = 1'b0;
    if (!keep_valid) key_valid = 1'b0;
    check("handshake_count", 128'(hs), 128'(11));
    check("post_rk_valid", 128'(rk_valid), 128'(0));
    check("post_key_ready", 128'(key_ready), 128'(1));
    check("post_busy", 128'(busy), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    check({tag, "_rk"}, rk, 128'(0));
    check({tag, "_rk_round"}, 128'(rk_round), 128'(0));
    check({tag, "_rk_last"}, 128'(rk_last), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    check({tag, "_state"}, 128'(dbg_state), 128'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int guard;
    ks_a = {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
            128'head27321b58dbad2312bf5607f8d292f, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'h6d88a37a110b3efddbf98641ca0093fd, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'hef44a541a8525b7fb671253bdb0bad00, 128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hf2c295f27a96b9435935807a7359f67f, 128'ha0fafe1788542cb123a339392a6c7605,
            128'h2b7e151628aed2a6abf7158809cf4f3c};
    ks_c = {128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h549932d1f08557681093ed9cbe2c974e,
            128'h47438735a41c65b9e016baf4aebf7ad2, 128'h14f9701ae35fe28c440adf4d4ea9c026,
            128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
            128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
            128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
            128'h000102030405060708090a0b0c0d0e0f};
    vecs[0] = '{key: ks_a[0], rks: ks_a, stall: 1'b0, poke: 1'b0};
    vecs[1] = '{key: ks_c[0], rks: ks_c, stall: 1'b0, poke: 1'b0};
    vecs[2] = '{key: ks_a[0], rks: ks_a, stall: 1'b1, poke: 1'b0};
    vecs[3] = '{key: ks_c[0], rks: ks_c, stall: 1'b1, poke: 1'b1};

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    rk_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_release");

    // Table-driven schedules: plain, stalled, stalled with keys poked while busy.
    for (int i = 0; i < 4; i++) begin
      run_key(vecs[i].key, vecs[i].rks, vecs[i].stall, vecs[i].poke, ~vecs[i].key, 1'b0);
      @(posedge clk); #1;
    end

    // Async reset while the round-5 key is presented.
    start_key(ks_a[0]);
    guard = 0;
    while (rk_valid !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    rk_ready = 1'b1;
    guard = 0;
    while (rk_round !== 4'd5 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_round", 128'(rk_round), 128'(5));
    check("abort_rk", rk, ks_a[5]);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_abort");
    rk_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort_release");
    run_key(ks_c[0], ks_c, 1'b0, 1'b0, '0, 1'b0);

    // Back-to-back: next key held valid through the whole first schedule.
    run_key(ks_a[0], ks_a, 1'b0, 1'b1, ks_c[0], 1'b1);
    run_key(ks_c[0], ks_c, 1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
